// File: rtl/shift_seq8_pkg.sv
// Shared constants for the multi-cycle shift sequencer: operation codes and FSM state encodings.
package shift_seq8_pkg;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_SHIFT = 2'b01;
  localparam logic [1:0] S_DONE  = 2'b10;

endpackage

// File: rtl/shifter8.sv
// Combinational 8-bit step shifter: shifts or rotates by 0..3 positions in one of four modes.
module shifter8
  import shift_seq8_pkg::*;
(
  input  logic [7:0] d_in_i,
  input  logic [1:0] op_i,
  input  logic [1:0] shamt_i,
  output logic [7:0] d_out_o
);

  logic [7:0] lsl_col [4];
  logic [7:0] lsr_col [4];
  logic [7:0] asr_col [4];
  logic [7:0] ror_col [4];

  always_comb begin
    lsl_col[0] = d_in_i;
    lsl_col[1] = {d_in_i[6:0], 1'b0};
    lsl_col[2] = {d_in_i[5:0], 2'b00};
    lsl_col[3] = {d_in_i[4:0], 3'b000};

    lsr_col[0] = d_in_i;
    lsr_col[1] = {1'b0, d_in_i[7:1]};
    lsr_col[2] = {2'b00, d_in_i[7:2]};
    lsr_col[3] = {3'b000, d_in_i[7:3]};

    asr_col[0] = d_in_i;
    asr_col[1] = {d_in_i[7], d_in_i[7:1]};
    asr_col[2] = {{2{d_in_i[7]}}, d_in_i[7:2]};
    asr_col[3] = {{3{d_in_i[7]}}, d_in_i[7:3]};

    ror_col[0] = d_in_i;
    ror_col[1] = {d_in_i[0], d_in_i[7:1]};
    ror_col[2] = {d_in_i[1:0], d_in_i[7:2]};
    ror_col[3] = {d_in_i[2:0], d_in_i[7:3]};
  end

  always_comb begin
    d_out_o = d_in_i;
    unique case (op_i)
      OP_LSL:  d_out_o = lsl_col[shamt_i];
      OP_LSR:  d_out_o = lsr_col[shamt_i];
      OP_ASR:  d_out_o = asr_col[shamt_i];
      OP_ROR:  d_out_o = ror_col[shamt_i];
      default: d_out_o = d_in_i;
    endcase
  end

endmodule

// File: rtl/shift_seq8.sv
// Multi-cycle shift sequencer: feeds the working register through a 0..3 step shifter until the
// full shift amount is consumed, with a start/busy/done handshake.
module shift_seq8
  import shift_seq8_pkg::*;
#(
  parameter int unsigned SH_W = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [SH_W-1:0] shamt_i,
  input  logic [7:0]      d_in_i,
  output logic [7:0]      d_out_o,
  output logic            busy_o,
  output logic            done_o
);

  logic [1:0]      state_q, state_d;
  logic [SH_W-1:0] rem_q, rem_d;
  logic [1:0]      op_q, op_d;
  logic [7:0]      data_q, data_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [1:0]      step;
  logic [SH_W-1:0] rem_after;
  logic [7:0]      step_result;

  // Largest step the shifter supports is 3; the tail step takes whatever remains.
  assign step      = (rem_q >= SH_W'(3)) ? 2'd3 : rem_q[1:0];
  assign rem_after = rem_q - SH_W'(step);

  shifter8 u_shifter8 (
    .d_in_i  (data_q),
    .op_i    (op_q),
    .shamt_i (step),
    .d_out_o (step_result)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      op_q    <= OP_LSL;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    op_d    = op_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_SHIFT;
          rem_d   = shamt_i;
          op_d    = op_i;
          data_d  = d_in_i;
        end
      end
      S_SHIFT: begin
        data_d = step_result;
        rem_d  = rem_after;
        if (rem_after == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Flags are registered from the next state so they line up with the state they describe.
  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  assign d_out_o = data_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_shift_seq8.sv
// Scoreboard bench for shift_seq8: stimulus queues expected results, a monitor checks each done.
module tb_shift_seq8;
  import shift_seq8_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] op;
  logic [2:0] shamt;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic       busy;
  logic       done;

  typedef struct {
    string      name;
    logic [7:0] exp;
    int         acc_cyc;
    int         lat;
  } sb_item_t;

  sb_item_t sb[$];
  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  shift_seq8 #(.SH_W(3)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .op_i    (op),
    .shamt_i (shamt),
    .d_in_i  (d_in),
    .d_out_o (d_out),
    .busy_o  (busy),
    .done_o  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        sb_item_t it;
        it = sb.pop_front();
        check({it.name, "_result"}, int'(d_out), int'(it.exp));
        check({it.name, "_latency"}, cyc - it.acc_cyc, it.lat);
        check({it.name, "_busy_in_done"}, int'(busy), 1);
      end
    end
  end

  // Issues a start pulse accepted at the next rising edge; returns at the negedge after it.
  task automatic start_op(input string name, input logic [1:0] o, input logic [2:0] s,
                          input logic [7:0] d, input logic [7:0] exp, input int n_shift);
    sb_item_t it;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    shamt = s;
    d_in  = d;
    it.name    = name;
    it.exp     = exp;
    it.acc_cyc = cyc + 1;
    it.lat     = n_shift;
    sb.push_back(it);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (sb.size() != 0) begin
      check({name, "_timeout"}, 1, 0);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = OP_LSL;
    shamt = 3'd0;
    d_in  = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_dout", int'(d_out), 8'h00);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_dout", int'(d_out), 8'h00);
      check("idle_busy", int'(busy), 0);
      check("idle_done", int'(done), 0);
    end

    // LSL 0x01 by 7: steps 3,3,1.
    start_op("lsl7", OP_LSL, 3'd7, 8'h01, 8'h80, 3);
    check("lsl7_busy_after_accept", int'(busy), 1);
    wait_done("lsl7");
    repeat (3) @(negedge clk);
    check("lsl7_held", int'(d_out), 8'h80);
    check("lsl7_idle_busy", int'(busy), 0);

    // ASR 0x80 by 5: steps 3,2.
    start_op("asr5", OP_ASR, 3'd5, 8'h80, 8'hFC, 2);
    @(negedge clk);
    check("asr5_step1", int'(d_out), 8'hF0);
    wait_done("asr5");

    start_op("ror4", OP_ROR, 3'd4, 8'h81, 8'h18, 2);
    wait_done("ror4");
    start_op("zero", OP_ROR, 3'd0, 8'h5A, 8'h5A, 1);
    wait_done("zero");

    // Second request during SHIFT must be ignored.
    start_op("lsr6", OP_LSR, 3'd6, 8'h0F, 8'h00, 2);
    start = 1'b1;
    d_in  = 8'hFF;
    shamt = 3'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done("lsr6");
    repeat (5) @(negedge clk);
    check("lsr6_held", int'(d_out), 8'h00);

    // Asynchronous reset mid-operation; abandon the outstanding request.
    start_op("abort", OP_LSL, 3'd7, 8'h03, 8'h00, 3);
    void'(sb.pop_back());
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_dout", int'(d_out), 8'h00);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    start_op("lsl2", OP_LSL, 3'd2, 8'h03, 8'h0C, 1);
    wait_done("lsl2");
    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_seq8.md
Name: shift_seq8

Overview:
- Multi-cycle sequencer that wraps a 2-bit-shamt 8-bit step shifter so it can perform shifts of 0..7 positions.
- Supports four operations: LSL, LSR, ASR and ROR.
- Each cycle it applies a step of min(remaining, 3) and feeds the result back until the full amount is consumed.
- Sits between the ALU control FSM and the shifter datapath, with a start/busy/done handshake.

Parameters:
- SH_W, 3, width of the shamt input. The maximum shift is 2^SH_W - 1.
- The data width is fixed at 8 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- op  input  2  operation code: 00 LSL, 01 LSR, 10 ASR (sign fill), 11 ROR.
- shamt  input  SH_W  total shift amount.
- d_in  input  8  operand.
- d_out  output  8  working/result register.
- busy  output  1  high from the cycle after accept through the DONE cycle.
- done  output  1  one-cycle pulse; d_out is valid in that cycle.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE, d_out=8'h00, busy=0, done=0, remaining=0, op_r=00.
  - Reset takes effect immediately, including mid-operation; no partial result survives.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1 at a rising edge: d_out<=d_in, op_r<=op, rem<=shamt, state<=SHIFT, busy<=1.
  - Otherwise d_out holds its value.
- SHIFT, each edge:
  - step = (rem>=3) ? 2'd3 : rem[1:0].
  - d_out <= stepshift(d_out, op_r, step).
  - rem <= rem - step.
  - If rem - step == 0, state<=DONE.
- shamt=0: exactly one SHIFT cycle with step 0, then DONE. d_out equals d_in.
- DONE:
  - done=1 and busy=1 for exactly one cycle.
  - Next edge: state<=IDLE, busy<=0, done<=0.
  - d_out holds the result until the next accepted start.
- Latency:
  - Let the accept edge be E0.
  - SHIFT edges are E1..EN, where N = max(1, ceil(shamt/3)).
  - done is high in the cycle following EN. For shamt=7: steps 3,3,1 on E1..E3.
  - Back-to-back: start may be asserted in the DONE cycle but is ignored. The earliest re-accept is in the IDLE cycle after DONE.
- start while busy: ignored. op, shamt and d_in changes while busy have no effect (all are latched at accept).
- Step semantics (per step k in 0..3):
  - LSL fills zeros at the LSB.
  - LSR fills zeros at the MSB.
  - ASR replicates bit7.
  - ROR rotates bits out of the LSB into the MSB.
  - Composition of steps must equal a single shift by shamt. For ROR this means modulo 8; for the others it saturates naturally.
- Outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package, constants only:
  - OP_LSL=2'b00, OP_LSR=2'b01, OP_ASR=2'b10, OP_ROR=2'b11.
  - State encodings S_IDLE=2'b00, S_SHIFT=2'b01, S_DONE=2'b10.
- One sub-module, shifter8: combinational 8-bit step shifter with ports d_in[7:0], op[1:0], shamt[1:0] and d_out[7:0].
  - Built from four 8-bit 4-to-1 mux columns (LSL/LSR/ASR/ROR) plus an op-select mux.
  - Instantiated once inside shift_seq8 in the feedback path.
- The sequencer holds the FSM, the rem counter and the d_out register.

Test Plan:
- Reset then idle:
  - Stimulus: reset_n low for 2 cycles, then high, start=0 for 5 cycles.
  - Required: d_out=8'h00, busy=0 and done=0 throughout.
- LSL by 7:
  - Stimulus: d_in=8'h01, op=00, shamt=7, start pulse.
  - Required: busy=1 on the next cycle; done pulses in the 4th cycle after accept; d_out=8'h80 in that cycle and held afterwards.
- ASR by 5:
  - Stimulus: d_in=8'h80, op=10, shamt=5.
  - Required: result 8'hFC; intermediate d_out after the first step is 8'hF0.
- ROR by 4, and shamt 0:
  - Stimulus: d_in=8'h81, op=11, shamt=4. Then d_in=8'h5A, shamt=0.
  - Required: first result 8'h18. Second result 8'h5A, with done in the 2nd cycle after accept.
- Start while busy:
  - Stimulus: d_in=8'h0F, op=01, shamt=6. During SHIFT, pulse start with d_in=8'hFF, shamt=1.
  - Required: the second request is ignored; result 8'h00; exactly one done pulse.
- Reset mid-operation:
  - Stimulus: assert reset_n=0 asynchronously between clock edges during SHIFT.
  - Required: d_out, busy and done go to 0 immediately; after release, a new LSL of 8'h03 by 2 yields 8'h0C.
